// File: rtl/pcie_trans_nvc.sv
// Transaction switch: main FIFO feeds per-VC FIFOs, and a VC arbiter drains them into two
// destination FIFOs. Thresholds provide back-pressure, and a five-state FSM gates the traffic.

module pcie_trans_nvc_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     ovf,
    output logic                     udf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_s, wr_ok_s, rd_ok_s;

    // Full/empty come from the pre-edge count, so a push to a full FIFO is lost even with a pop
    assign full_s  = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign wr_ok_s = push & ~full_s;
    assign rd_ok_s = pop & ~empty;
    assign ovf     = push & full_s;
    assign udf     = pop & empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module pcie_trans_nvc #(
    parameter int DATA_W   = 6,
    parameter int NVC      = 4,
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4,
    parameter int ARB_RR   = 0
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        init,
    input  logic [$clog2(MF_DEPTH):0]   umbral_mf,
    input  logic [$clog2(VC_DEPTH):0]   umbral_vc,
    input  logic [$clog2(D_DEPTH):0]    umbral_d,
    input  logic                        push,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        pop_d0,
    input  logic                        pop_d1,
    output logic [DATA_W-1:0]           data_out0,
    output logic [DATA_W-1:0]           data_out1,
    output logic                        empty_d0,
    output logic                        empty_d1,
    output logic                        pausa_mf,
    output logic                        active_out,
    output logic                        idle_out,
    output logic                        error_out
);
    localparam int VW  = $clog2(NVC);
    localparam int MCW = $clog2(MF_DEPTH) + 1;
    localparam int VCW = $clog2(VC_DEPTH) + 1;
    localparam int DCW = $clog2(D_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [MCW-1:0] thr_mf_q, thr_mf_d;
    logic [VCW-1:0] thr_vc_q, thr_vc_d;
    logic [DCW-1:0] thr_d_q, thr_d_d;
    logic [VW-1:0]  last_grant_q, last_grant_d;
    logic           active_out_q, active_out_d;
    logic           idle_out_q, idle_out_d;
    logic           error_out_q, error_out_d;

    logic              run_s, mf_push_s, mf_pop_s, mf_empty_s, mf_ovf_s, mf_udf_s;
    logic [DATA_W-1:0] mf_head_s;
    logic [MCW-1:0]    mf_count_s;
    logic [VW-1:0]     mf_idx_s;

    logic [DATA_W-1:0] vc_head_s  [NVC];
    logic [VCW-1:0]    vc_count_s [NVC];
    logic [NVC-1:0]    vc_push_s, vc_pop_s, vc_empty_s, vc_ovf_s, vc_udf_s, elig_s;

    logic [VW-1:0]     base_s, cand_s, grant_idx_s;
    logic              grant_s, gnt_to_d1_s;
    logic [DATA_W-1:0] gnt_head_s;

    logic              d0_push_s, d1_push_s;
    logic              d0_ovf_s, d0_udf_s, d1_ovf_s, d1_udf_s;
    logic [DCW-1:0]    d0_count_s, d1_count_s;
    logic              any_err_s, all_empty_s;

    assign run_s     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign mf_push_s = push & run_s;

    pcie_trans_nvc_fifo #(.W(DATA_W), .DEPTH(MF_DEPTH)) u_mf (
        .clk(clk), .reset_L(reset_L), .push(mf_push_s), .pop(mf_pop_s), .din(data_in),
        .dout(mf_head_s), .count(mf_count_s), .empty(mf_empty_s), .ovf(mf_ovf_s), .udf(mf_udf_s)
    );

    for (genvar k = 0; k < NVC; k++) begin : g_vc
        pcie_trans_nvc_fifo #(.W(DATA_W), .DEPTH(VC_DEPTH)) u_vc (
            .clk(clk), .reset_L(reset_L), .push(vc_push_s[k]), .pop(vc_pop_s[k]), .din(mf_head_s),
            .dout(vc_head_s[k]), .count(vc_count_s[k]), .empty(vc_empty_s[k]),
            .ovf(vc_ovf_s[k]), .udf(vc_udf_s[k])
        );
    end

    pcie_trans_nvc_fifo #(.W(DATA_W), .DEPTH(D_DEPTH)) u_d0 (
        .clk(clk), .reset_L(reset_L), .push(d0_push_s), .pop(pop_d0), .din(gnt_head_s),
        .dout(data_out0), .count(d0_count_s), .empty(empty_d0), .ovf(d0_ovf_s), .udf(d0_udf_s)
    );

    pcie_trans_nvc_fifo #(.W(DATA_W), .DEPTH(D_DEPTH)) u_d1 (
        .clk(clk), .reset_L(reset_L), .push(d1_push_s), .pop(pop_d1), .din(gnt_head_s),
        .dout(data_out1), .count(d1_count_s), .empty(empty_d1), .ovf(d1_ovf_s), .udf(d1_udf_s)
    );

    // Head-of-line move from main FIFO into the VC named by the head word
    always_comb begin
        mf_idx_s  = mf_head_s[DATA_W-2 -: VW];
        mf_pop_s  = 1'b0;
        vc_push_s = '0;
        if (run_s && !mf_empty_s && (vc_count_s[mf_idx_s] < thr_vc_q)) begin
            mf_pop_s            = 1'b1;
            vc_push_s[mf_idx_s] = 1'b1;
        end else begin
            mf_pop_s = 1'b0;
        end
    end

    // A VC competes only if its head's destination still has room under the threshold
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < NVC; k++) begin
            elig_s[k] = run_s & ~vc_empty_s[k] &
                        ((vc_head_s[k][DATA_W-1] ? d1_count_s : d0_count_s) < thr_d_q);
        end
    end

    // Descending scan so the candidate closest to the search base wins
    always_comb begin
        base_s      = (ARB_RR != 0) ? (last_grant_q + VW'(1)) : '0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int i = NVC - 1; i >= 0; i--) begin
            cand_s      = base_s + VW'(i);
            grant_idx_s = elig_s[cand_s] ? cand_s : grant_idx_s;
            grant_s     = grant_s | elig_s[cand_s];
        end
        gnt_head_s   = vc_head_s[grant_idx_s];
        gnt_to_d1_s  = gnt_head_s[DATA_W-1];
        vc_pop_s     = '0;
        vc_pop_s[grant_idx_s] = grant_s;
        d0_push_s    = grant_s & ~gnt_to_d1_s;
        d1_push_s    = grant_s & gnt_to_d1_s;
        last_grant_d = grant_s ? grant_idx_s : last_grant_q;
    end

    assign any_err_s   = mf_ovf_s | mf_udf_s | (|vc_ovf_s) | (|vc_udf_s) |
                         d0_ovf_s | d0_udf_s | d1_ovf_s | d1_udf_s;
    assign all_empty_s = mf_empty_s & (&vc_empty_s) & empty_d0 & empty_d1;
    assign pausa_mf    = (mf_count_s >= thr_mf_q);

    // Control FSM, threshold capture and registered status flags
    always_comb begin
        state_d  = state_q;
        thr_mf_d = thr_mf_q;
        thr_vc_d = thr_vc_q;
        thr_d_d  = thr_d_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    thr_mf_d = umbral_mf;
                    thr_vc_d = umbral_vc;
                    thr_d_d  = umbral_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (any_err_s) begin
                    state_d = ST_ERROR;
                end else if (all_empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                if (init) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_RESET;
        endcase
        active_out_d = (state_d == ST_ACTIVE);
        idle_out_d   = (state_d == ST_IDLE);
        error_out_d  = (state_d == ST_ERROR);
    end

    // Control registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_RESET;
            thr_mf_q     <= MCW'(MF_DEPTH - 1);
            thr_vc_q     <= VCW'(VC_DEPTH - 1);
            thr_d_q      <= DCW'(D_DEPTH - 1);
            last_grant_q <= VW'(NVC - 1);
            active_out_q <= 1'b0;
            idle_out_q   <= 1'b0;
            error_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_mf_q     <= thr_mf_d;
            thr_vc_q     <= thr_vc_d;
            thr_d_q      <= thr_d_d;
            last_grant_q <= last_grant_d;
            active_out_q <= active_out_d;
            idle_out_q   <= idle_out_d;
            error_out_q  <= error_out_d;
        end
    end

    assign active_out = active_out_q;
    assign idle_out   = idle_out_q;
    assign error_out  = error_out_q;
endmodule

// File: tb/tb_pcie_trans_nvc.sv
// Directed bench for pcie_trans_nvc: a fixed-priority and a round-robin instance share
// one stimulus stream.

module tb_pcie_trans_nvc;
    logic       clk = 1'b0;
    logic       reset_L, init, push, pop_d0, pop_d1;
    logic [2:0] umbral_mf, umbral_d;
    logic [4:0] umbral_vc;
    logic [5:0] data_in;

    logic [5:0] a_data_out0, a_data_out1, b_data_out0, b_data_out1;
    logic a_empty_d0, a_empty_d1, a_pausa_mf, a_active_out, a_idle_out, a_error_out;
    logic b_empty_d0, b_empty_d1, b_pausa_mf, b_active_out, b_idle_out, b_error_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [5:0] exp_fix [6] = '{6'h01, 6'h02, 6'h03, 6'h11, 6'h12, 6'h13};
    logic [5:0] exp_rr  [6] = '{6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13};

    always #5 clk = ~clk;

    pcie_trans_nvc #(.ARB_RR(0)) u_fix (
        .clk(clk), .reset_L(reset_L), .init(init), .umbral_mf(umbral_mf), .umbral_vc(umbral_vc),
        .umbral_d(umbral_d), .push(push), .data_in(data_in), .pop_d0(pop_d0), .pop_d1(pop_d1),
        .data_out0(a_data_out0), .data_out1(a_data_out1), .empty_d0(a_empty_d0),
        .empty_d1(a_empty_d1), .pausa_mf(a_pausa_mf), .active_out(a_active_out),
        .idle_out(a_idle_out), .error_out(a_error_out)
    );

    pcie_trans_nvc #(.ARB_RR(1)) u_rr (
        .clk(clk), .reset_L(reset_L), .init(init), .umbral_mf(umbral_mf), .umbral_vc(umbral_vc),
        .umbral_d(umbral_d), .push(push), .data_in(data_in), .pop_d0(pop_d0), .pop_d1(pop_d1),
        .data_out0(b_data_out0), .data_out1(b_data_out1), .empty_d0(b_empty_d0),
        .empty_d1(b_empty_d1), .pausa_mf(b_pausa_mf), .active_out(b_active_out),
        .idle_out(b_idle_out), .error_out(b_error_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init = 1'b0; push = 1'b0; pop_d0 = 1'b0; pop_d1 = 1'b0; data_in = 6'h00;
        umbral_mf = 3'd3; umbral_vc = 5'd15; umbral_d = 3'd3;
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        tick();
        tick();
    endtask

    task automatic load_thr(input logic [2:0] mf, input logic [4:0] vc, input logic [2:0] d);
        umbral_mf = mf; umbral_vc = vc; umbral_d = d;
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [5:0] w);
        data_in = w;
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b1; init = 1'b0; push = 1'b0; pop_d0 = 1'b0; pop_d1 = 1'b0; data_in = 6'h00;
        umbral_mf = 3'd3; umbral_vc = 5'd15; umbral_d = 3'd3;
        #2 reset_L = 1'b0;
        #1;
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL rst_empty_d0: got %b exp 1", a_empty_d0); else pass_cnt++;
        total_cnt++; if (a_empty_d1 !== 1'b1) $display("FAIL rst_empty_d1: got %b exp 1", a_empty_d1); else pass_cnt++;
        total_cnt++; if (a_pausa_mf !== 1'b0) $display("FAIL rst_pausa: got %b exp 0", a_pausa_mf); else pass_cnt++;
        total_cnt++; if (a_active_out !== 1'b0) $display("FAIL rst_active: got %b exp 0", a_active_out); else pass_cnt++;
        total_cnt++; if (a_idle_out !== 1'b0) $display("FAIL rst_idle: got %b exp 0", a_idle_out); else pass_cnt++;
        total_cnt++; if (a_error_out !== 1'b0) $display("FAIL rst_error: got %b exp 0", a_error_out); else pass_cnt++;
        tick();
        reset_L = 1'b1;
        tick();
        total_cnt++; if (a_idle_out !== 1'b0) $display("FAIL rst_init_state: idle got %b exp 0", a_idle_out); else pass_cnt++;
        tick();
        total_cnt++; if (a_idle_out !== 1'b1) $display("FAIL rst_to_idle: idle got %b exp 1", a_idle_out); else pass_cnt++;
    endtask

    task automatic test_basic();
        load_thr(3'd3, 5'd15, 3'd3);
        total_cnt++; if (a_idle_out !== 1'b1) $display("FAIL basic_init_idle: got %b exp 1", a_idle_out); else pass_cnt++;
        push_word(6'h05);
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL basic_e0_empty: got %b exp 1", a_empty_d0); else pass_cnt++;
        tick();
        total_cnt++; if (a_active_out !== 1'b1 || a_idle_out !== 1'b0)
            $display("FAIL basic_active: got act=%b idle=%b exp act=1 idle=0", a_active_out, a_idle_out); else pass_cnt++;
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL basic_e1_empty: got %b exp 1", a_empty_d0); else pass_cnt++;
        tick();
        total_cnt++; if (a_empty_d0 !== 1'b0 || a_data_out0 !== 6'h05)
            $display("FAIL basic_deliver: got empty=%b data=%h exp empty=0 data=05", a_empty_d0, a_data_out0); else pass_cnt++;
        total_cnt++; if (a_empty_d1 !== 1'b1) $display("FAIL basic_d1_untouched: got %b exp 1", a_empty_d1); else pass_cnt++;
        pop_d0 = 1'b1;
        tick();
        pop_d0 = 1'b0;
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL basic_pop_empty: got %b exp 1", a_empty_d0); else pass_cnt++;
        tick();
        total_cnt++; if (a_idle_out !== 1'b1 || a_error_out !== 1'b0)
            $display("FAIL basic_back_idle: got idle=%b err=%b exp idle=1 err=0", a_idle_out, a_error_out); else pass_cnt++;
    endtask

    task automatic test_arbiter();
        do_reset();
        load_thr(3'd3, 5'd15, 3'd0);
        push_word(6'h01); push_word(6'h02); push_word(6'h03);
        push_word(6'h11); push_word(6'h12); push_word(6'h13);
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL arb_held_by_thr: empty got %b exp 1", a_empty_d0); else pass_cnt++;
        load_thr(3'd3, 5'd15, 3'd4);
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 6; i++) begin
            total_cnt++; if (a_data_out0 !== exp_fix[i])
                $display("FAIL arb_fixed_%0d: got %h exp %h", i, a_data_out0, exp_fix[i]); else pass_cnt++;
            total_cnt++; if (b_data_out0 !== exp_rr[i])
                $display("FAIL arb_rr_%0d: got %h exp %h", i, b_data_out0, exp_rr[i]); else pass_cnt++;
            pop_d0 = 1'b1;
            tick();
            pop_d0 = 1'b0;
            tick();
            tick();
        end
        total_cnt++; if (a_empty_d0 !== 1'b1 || b_empty_d0 !== 1'b1)
            $display("FAIL arb_drained: got fix=%b rr=%b exp 1 1", a_empty_d0, b_empty_d0); else pass_cnt++;
        total_cnt++; if (a_error_out !== 1'b0 || b_error_out !== 1'b0)
            $display("FAIL arb_no_error: got fix=%b rr=%b exp 0 0", a_error_out, b_error_out); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        load_thr(3'd3, 5'd2, 3'd2);
        for (int i = 1; i <= 5; i++) push_word(6'(i));
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (a_pausa_mf !== 1'b0) $display("FAIL bp_pausa_cnt1: got %b exp 0", a_pausa_mf); else pass_cnt++;
        push_word(6'h06);
        total_cnt++; if (a_pausa_mf !== 1'b0) $display("FAIL bp_pausa_cnt2: got %b exp 0", a_pausa_mf); else pass_cnt++;
        push_word(6'h07);
        total_cnt++; if (a_pausa_mf !== 1'b1) $display("FAIL bp_pausa_cnt3: got %b exp 1", a_pausa_mf); else pass_cnt++;
        total_cnt++; if (a_error_out !== 1'b0 || a_active_out !== 1'b1)
            $display("FAIL bp_state: got err=%b act=%b exp err=0 act=1", a_error_out, a_active_out); else pass_cnt++;
        total_cnt++; if (a_data_out0 !== 6'h01) $display("FAIL bp_head0: got %h exp 01", a_data_out0); else pass_cnt++;
        pop_d0 = 1'b1;
        tick();
        total_cnt++; if (a_data_out0 !== 6'h02) $display("FAIL bp_only_two: got %h exp 02", a_data_out0); else pass_cnt++;
        tick();
        pop_d0 = 1'b0;
        total_cnt++; if (a_data_out0 !== 6'h03) $display("FAIL bp_resume: got %h exp 03", a_data_out0); else pass_cnt++;
        total_cnt++; if (a_error_out !== 1'b0) $display("FAIL bp_no_error: got %b exp 0", a_error_out); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        load_thr(3'd3, 5'd0, 3'd3);
        for (int i = 1; i <= 4; i++) push_word(6'(i));
        total_cnt++; if (a_pausa_mf !== 1'b1 || a_error_out !== 1'b0)
            $display("FAIL ovf_full: got pausa=%b err=%b exp 1 0", a_pausa_mf, a_error_out); else pass_cnt++;
        push_word(6'h05);
        total_cnt++; if (a_error_out !== 1'b1 || a_active_out !== 1'b0)
            $display("FAIL ovf_error: got err=%b act=%b exp 1 0", a_error_out, a_active_out); else pass_cnt++;
        push_word(6'h06);
        total_cnt++; if (a_error_out !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", a_error_out); else pass_cnt++;
        load_thr(3'd3, 5'd15, 3'd3);
        total_cnt++; if (a_error_out !== 1'b0 || a_idle_out !== 1'b1)
            $display("FAIL ovf_clear: got err=%b idle=%b exp 0 1", a_error_out, a_idle_out); else pass_cnt++;
        tick();
        total_cnt++; if (a_active_out !== 1'b1) $display("FAIL ovf_active: got %b exp 1", a_active_out); else pass_cnt++;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 1; i <= 4; i++) begin
            total_cnt++; if (a_data_out0 !== 6'(i))
                $display("FAIL ovf_word_%0d: got %h exp %h", i, a_data_out0, 6'(i)); else pass_cnt++;
            pop_d0 = 1'b1;
            tick();
            pop_d0 = 1'b0;
            tick();
            tick();
        end
        total_cnt++; if (a_empty_d0 !== 1'b1) $display("FAIL ovf_dropped: empty got %b exp 1", a_empty_d0); else pass_cnt++;
        total_cnt++; if (a_idle_out !== 1'b1 || a_error_out !== 1'b0)
            $display("FAIL ovf_end: got idle=%b err=%b exp 1 0", a_idle_out, a_error_out); else pass_cnt++;
    endtask

    task automatic test_underflow_async();
        do_reset();
        pop_d1 = 1'b1;
        tick();
        pop_d1 = 1'b0;
        total_cnt++; if (a_error_out !== 1'b1 || b_error_out !== 1'b1)
            $display("FAIL udf_error: got fix=%b rr=%b exp 1 1", a_error_out, b_error_out); else pass_cnt++;
        load_thr(3'd3, 5'd15, 3'd3);
        total_cnt++; if (a_error_out !== 1'b0) $display("FAIL udf_clear: got %b exp 0", a_error_out); else pass_cnt++;
        push_word(6'h21); push_word(6'h22); push_word(6'h23);
        total_cnt++; if (a_empty_d1 !== 1'b0 || a_data_out1 !== 6'h21)
            $display("FAIL udf_stream: got empty=%b data=%h exp 0 21", a_empty_d1, a_data_out1); else pass_cnt++;
        total_cnt++; if (a_active_out !== 1'b1) $display("FAIL udf_active: got %b exp 1", a_active_out); else pass_cnt++;
        #3 reset_L = 1'b0;
        #1;
        total_cnt++; if (a_empty_d1 !== 1'b1 || a_empty_d0 !== 1'b1)
            $display("FAIL async_empty: got d0=%b d1=%b exp 1 1", a_empty_d0, a_empty_d1); else pass_cnt++;
        total_cnt++; if (a_active_out !== 1'b0 || a_idle_out !== 1'b0 || a_error_out !== 1'b0 || a_pausa_mf !== 1'b0)
            $display("FAIL async_flags: got act=%b idle=%b err=%b pausa=%b exp 0 0 0 0",
                     a_active_out, a_idle_out, a_error_out, a_pausa_mf); else pass_cnt++;
        tick();
        reset_L = 1'b1;
        tick();
        total_cnt++; if (a_idle_out !== 1'b0) $display("FAIL async_init: idle got %b exp 0", a_idle_out); else pass_cnt++;
        tick();
        total_cnt++; if (a_idle_out !== 1'b1 || a_empty_d1 !== 1'b1)
            $display("FAIL async_idle: got idle=%b empty_d1=%b exp 1 1", a_idle_out, a_empty_d1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbiter();
        test_backpressure();
        test_overflow();
        test_underflow_async();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pcie_trans_nvc.md
PCIE_TRANS_NVC -- requirements
Module: pcie_trans_nvc

Interface
REQ-001 SHALL have parameter DATA_W, default 6, meaning word width; bit DATA_W-1 selects destination (0 = D0, 1 = D1).
REQ-002 SHALL have parameter NVC, default 4, meaning virtual-channel count; legal values 2 or 4; VC index = data_in[DATA_W-2 -: log2(NVC)].
REQ-003 SHALL have parameters MF_DEPTH = 4, VC_DEPTH = 16 and D_DEPTH = 4, meaning main-, per-VC and per-destination FIFO depths (powers of two).
REQ-004 SHALL have parameter ARB_RR, default 0, meaning VC arbiter mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port reset_L, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have port init, input, 1 bit, meaning threshold-load / error-clear request.
REQ-008 SHALL have ports umbral_mf, umbral_vc, umbral_d, inputs, log2(depth)+1 bits each, meaning pause thresholds, sampled only in INIT.
REQ-009 SHALL have ports push (input, 1) and data_in (input, DATA_W), meaning the write strobe and word into the main FIFO.
REQ-010 SHALL have ports pop_d0 and pop_d1, inputs, 1 bit each, meaning read strobes of the destination FIFOs.
REQ-011 SHALL have ports data_out0 and data_out1 (outputs, DATA_W), meaning show-ahead destination heads, plus empty_d0 and empty_d1 (outputs, 1 bit each).
REQ-012 SHALL have ports pausa_mf, active_out, idle_out and error_out, outputs, 1 bit each, meaning source back-pressure and the FSM status flags.

Function
REQ-013 SHALL make all FIFOs show-ahead, with full/empty evaluated on the pre-edge count; a push to a full FIFO SHALL be dropped and flag overflow even when a pop occurs in the same cycle; a pop of an empty FIFO SHALL be ignored and flag underflow.
REQ-014 SHALL wrap FIFO pointers modulo depth and keep count in 0..depth.
REQ-015 SHALL drive pausa_mf = (count_mf >= thr_mf) combinationally.
REQ-016 SHALL, per cycle in IDLE/ACTIVE, move the MF head to VC[idx] when MF is non-empty and count_vc[idx] < thr_vc; otherwise MF stalls (head-of-line); latency one cycle; MF pop and external push in the same cycle SHALL be legal.
REQ-017 SHALL deem VC k eligible when non-empty and the count of its head's destination FIFO is < thr_d.
REQ-018 SHALL grant at most one eligible VC per cycle, popping it and pushing its head into D0/D1 on the same edge; latency one cycle VC-to-destination.
REQ-019 SHALL, when ARB_RR = 1, search from (last_grant+1) mod NVC and update last_grant only on a grant; last_grant resets to NVC-1.
REQ-020 SHALL accept external push only in IDLE/ACTIVE; pushes in INIT/ERROR are dropped without error; pop_d0/pop_d1 are honoured in every state.
REQ-021 SHALL implement FSM states RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-022 SHALL transition RESET -> INIT unconditionally on the first edge after reset release.
REQ-023 SHALL stay in INIT while init = 1, latching umbral_* each cycle; on init = 0 it SHALL go to IDLE.
REQ-024 SHALL go IDLE <-> ACTIVE: IDLE when all FIFOs are empty, else ACTIVE.
REQ-025 SHALL enter ERROR from IDLE/ACTIVE on any overflow/underflow; ERROR is sticky until init = 1 (-> INIT) or reset.
REQ-026 SHALL give init = 1 in IDLE/ACTIVE priority and go to INIT; FIFO contents are kept.
REQ-027 SHALL drive active_out = ACTIVE, idle_out = IDLE and error_out = ERROR, all registered.
REQ-028 SHALL suspend MF-to-VC and VC-to-D transfers in RESET, INIT and ERROR.

Reset
REQ-029 SHALL, on reset_L = 0, immediately clear all pointers and counts, set state RESET, clear all status outputs, and set empty_d0 = empty_d1 = 1 and pausa_mf = 0.
REQ-030 SHALL reset thresholds to thr_mf = MF_DEPTH-1, thr_vc = VC_DEPTH-1 and thr_d = D_DEPTH-1.
REQ-031 SHALL, when reset asserts mid-transfer, discard in-flight words; data_out0/1 are don't-care while empty.

Verification
REQ-032 Defaults; init pulse; push 0x05 (VC index from bits [4:3] = 0, D0) -> idle_out=0, active_out=1; the word appears on data_out0 two cycles after MF entry; pop_d0 -> idle_out=1.
REQ-033 ARB_RR = 0, D0 popped slowly, VC0 and VC2 both loaded with 3 words each -> all VC0 words are delivered before any VC2 word; with ARB_RR = 1 -> grants alternate VC0, VC2, VC0, ...
REQ-034 thr_d = 2, no pops -> D0 holds exactly 2 words and VC flow stops; MF fills; pausa_mf = 1 when count_mf = 3; no error.
REQ-035 Push while MF is full (4 words, transfers blocked) -> word dropped; error_out = 1 next cycle; further pushes ignored; init -> INIT then IDLE/ACTIVE; error_out = 0.
REQ-036 pop_d1 with D1 empty -> error_out = 1; asynchronous reset mid-stream -> all outputs at reset values within the same cycle, state INIT one edge after release.
